// File: rtl/vector_serializer.sv
// vector_serializer
//   Parallel-in, serial-out lane unloader. One WIDTH*DEPTH-bit word is taken
//   per input handshake and emitted as DEPTH WIDTH-bit lanes on a valid/ready
//   stream, most-significant lane first. A sink that shifts the lanes left into
//   a DEPTH x WIDTH register gets the original word back bit-exact.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   in_data    parallel word, lane k = in_data[WIDTH*(k+1)-1 : WIDTH*k]
//   in_valid   in_data is valid
//   in_ready   a word can be loaded this cycle (combinational from out_ready)
//   out_data   current lane (top slice of the shift register)
//   out_valid  out_data is valid
//   out_ready  sink accepts out_data this cycle
//   out_last   current lane is lane 0, the final lane of the word
module vector_serializer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH*DEPTH-1:0] in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last
);

  localparam int VEC_W = WIDTH * DEPTH;
  localparam int CNT_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [VEC_W-1:0]   s_reg, s_next;

  logic busy;
  logic at_last;
  logic load;
  logic beat;

  assign busy    = (state_reg == SEND);
  assign at_last = (cnt_reg == CNT_LAST);

  // A new word may enter while the final lane is being accepted, which is
  // what gives back-to-back words with no idle cycle in between.
  assign in_ready = !busy || (out_ready && at_last);
  assign load     = in_valid && in_ready;
  assign beat     = busy && out_ready;

  // Outputs are pure functions of registered state (plus out_ready for
  // in_ready); nothing on the input data path reaches them combinationally.
  assign out_data  = s_reg[VEC_W-1 -: WIDTH];
  assign out_valid = busy;
  assign out_last  = busy && at_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      s_reg     <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      s_reg     <= s_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    s_next     = s_reg;
    unique case (state_reg)
      IDLE: begin
        if (load) begin
          state_next = SEND;
          cnt_next   = '0;
          s_next     = in_data;
        end
      end
      SEND: begin
        if (beat) begin
          if (at_last) begin
            if (load) begin
              // Final lane leaves as the next word arrives: stay in SEND.
              cnt_next = '0;
              s_next   = in_data;
            end else begin
              state_next = IDLE;
              cnt_next   = '0;
              s_next     = '0;
            end
          end else begin
            // Left shift with zero fill; the sink reassembles by shifting left.
            cnt_next = cnt_reg + CNT_W'(1);
            s_next   = {s_reg[VEC_W-WIDTH-1:0], {WIDTH{1'b0}}};
          end
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
        s_next     = '0;
      end
    endcase
  end

endmodule

// File: doc/vector_serializer.md
# vector_serializer

Parallel-in, serial-out lane unloader. It accepts one `WIDTH*DEPTH`-bit word per handshake and emits it as `DEPTH` consecutive `WIDTH`-bit lanes on a valid/ready stream, most-significant lane first. It is the transmit-side counterpart of the serial-in vector shift path. A lane stream emitted here and shifted into a `DEPTH`-stage, `WIDTH`-wide serial-in shift register reassembles the original word bit-exact.

## Interface
Parameters:
- `WIDTH`, 8, lane width in bits.
- `DEPTH`, 4, lanes per word; legal range is `DEPTH >= 2`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_data`  in  `WIDTH*DEPTH`  parallel word; lane k is bits `[WIDTH*(k+1)-1 : WIDTH*k]`.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  block can load a word this cycle.
- `out_data`  out  `WIDTH`  current lane.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  sink accepts `out_data` this cycle.
- `out_last`  out  1  current lane is lane 0, the final lane of the word.

## Operation
- State consists of:
  - `busy` (1 bit)
  - lane counter `cnt` (`$clog2(DEPTH)` bits)
  - shift register `s_reg` (`WIDTH*DEPTH` bits)
- Two states:
  - IDLE: `busy=0`.
  - SEND: `busy=1`.
- Handshake definitions:
  - Load: `in_valid && in_ready`.
  - Beat: `out_valid && out_ready`.
  - The final beat is a beat with `cnt==DEPTH-1`.
- IDLE → SEND on a load:
  - `s_reg` ← `in_data`.
  - `cnt` ← 0.
- SEND, beat that is not the final beat:
  - `s_reg` ← `{s_reg[WIDTH*(DEPTH-1)-1:0], {WIDTH{1'b0}}}`.
  - `cnt` ← `cnt+1`.
- SEND, final beat with a simultaneous load: reload `s_reg` and clear `cnt`; stay in SEND with no bubble.
- SEND, final beat without a load: go to IDLE and clear `s_reg` to 0.
- SEND with no beat: hold `s_reg` and `cnt`; `out_data` remains stable while `out_valid` is high.
- Output and ready equations:
  - `out_data` = `s_reg[WIDTH*DEPTH-1 : WIDTH*(DEPTH-1)]`.
  - `out_valid` = `busy`.
  - `out_last` = `busy && cnt==DEPTH-1`.
  - `in_ready` = `!busy || (out_ready && cnt==DEPTH-1)`. This is combinational from `out_ready`; `in_ready` does not depend on `in_valid`.
- `in_valid` while `in_ready` is low is not a load. The producer holds `in_data` until it sees `in_ready`.
- `out_valid` never drops without a beat.

## Timing
- Reset values: `busy=0`, `cnt=0`, `s_reg=0`. Outputs at reset: `out_valid=0`, `out_last=0`, `out_data=0`, `in_ready=1`.
- Reset is asynchronous. When asserted mid-word, the partially sent word is discarded immediately, with no further beats. The first edge after deassertion behaves as IDLE.
- Latency: a load at edge N presents lane `DEPTH-1` with `out_valid=1` after edge N, i.e. in the same cycle as the registered update.
- Throughput: with `out_ready` held high and words always offered, the block sends one lane per cycle and `DEPTH` cycles per word, with zero idle cycles between words.
- Backpressure: each low cycle of `out_ready` adds exactly one cycle to the word.
- No combinational path exists from `in_valid`/`in_data` to any output.

## Structure
- Single self-contained module; no sub-module.
- No shared package entries. The counter width is a local constant, `$clog2(DEPTH)`.
- The shift register is inline. Its left-shift direction and zero fill are part of the contract: the sink reassembles the word by shifting left.

## Test plan
Directed scenarios, all with `WIDTH=8`, `DEPTH=4`:
- **Basic word:** `in_data=32'hA1B2C3D4`, `out_ready=1` → `out_data` A1, B2, C3, D4 on four consecutive cycles; `out_last` high only on D4; `in_ready` low during A1–C3.
- **Back-to-back:** words `32'h11223344` then `32'h55667788` offered continuously → eight beats 11..88 with no gap; the second load coincides with the beat of 44.
- **Backpressure:** `out_ready` low for 3 cycles after beat B2 → C3 is held stable with `out_valid=1` during the stall; the word completes on cycle 7 after load.
- **Busy ignore:** `in_valid=1` with `32'hDEADBEEF` during a word with `out_ready=1` → accepted only on the final beat. DE follows the last lane with no gap; no lanes are corrupted.
- **Reset mid-word:** assert `reset` after beat B2 → `out_valid`, `out_data` and `out_last` go to 0 without a clock edge; `in_ready=1`. After release, a new word serializes correctly from its top lane.
- **Round trip:** random words under random `out_ready` → captured lanes, shifted left into a 4×8 register, equal the source word for every word.
